// File: rtl/fpu_pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// FpuPipeCtrlIf : handshake bundle for fpu_pipe_ctrl
//
// Groups the upstream operation channel and the downstream result channel.
//   in_valid / in_ready            operation handshake
//   in_opd1, in_opd2, in_op        IEEE-754 single operands and opcode
//   in_tag                         opaque tag travelling with the operation
//   out_valid / out_ready          result handshake
//   out_res, out_flags, out_tag    result, {ovf, unf, nan, zero}, tag
//
// master : the environment (drives operations, consumes results)
// slave  : the pipeline controller
// ---------------------------------------------------------------------------
interface fpu_pipe_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_opd1;
  logic [31:0]      in_opd2;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_res;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_opd1, in_opd2, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_flags, out_tag
  );

  modport slave (
    input  in_valid, in_opd1, in_opd2, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_flags, out_tag
  );
endinterface

// File: rtl/fpu_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_pipe_ctrl : two-stage issue/retire wrapper around a combinational fpu
//
// Stage 1 registers an accepted operation and drives the fpu inputs from
// those registers. Stage 2 captures the fpu result and flags and presents
// them downstream. Sticky exception flags and a retired-operation counter
// are kept alongside.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   bus (slave)         operation in / result out handshakes
//   o_fpu_opd1/2, o_fpu_op   stage-1 operands and opcode to the fpu
//   i_fpu_res           fpu result
//   i_fpu_ovf/unf/nan/zero   fpu exception and zero flags
//   i_flag_clr          clear sticky flags
//   o_sticky_flags      {ovf, unf, nan} accumulated over retired results
//   o_retired_cnt       wrapping count of output handshakes
// ---------------------------------------------------------------------------
module fpu_pipe_ctrl #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fpu_pipe_ctrl_if.slave   bus,
  output logic [31:0]      o_fpu_opd1,
  output logic [31:0]      o_fpu_opd2,
  output logic [1:0]       o_fpu_op,
  input  logic [31:0]      i_fpu_res,
  input  logic             i_fpu_ovf,
  input  logic             i_fpu_unf,
  input  logic             i_fpu_nan,
  input  logic             i_fpu_zero,
  input  logic             i_flag_clr,
  output logic [2:0]       o_sticky_flags,
  output logic [CNT_W-1:0] o_retired_cnt
);

  logic             r_s1Valid;
  logic [31:0]      r_s1Opd1;
  logic [31:0]      r_s1Opd2;
  logic [1:0]       r_s1Op;
  logic [TAG_W-1:0] r_s1Tag;

  logic             r_outValid;
  logic [31:0]      r_outRes;
  logic [3:0]       r_outFlags;
  logic [TAG_W-1:0] r_outTag;

  logic [2:0]       r_sticky;
  logic [CNT_W-1:0] r_retiredCnt;

  logic w_s2Load;
  logic w_inReady;
  logic w_inFire;
  logic w_retire;

  // Stage 2 can take stage 1 whenever it is empty or draining this cycle;
  // stage 1 in turn frees up when it is empty or being moved forward. This
  // makes in_ready depend combinationally on out_ready, which is what lets
  // the pipe sustain one operation per cycle.
  assign w_s2Load  = r_s1Valid && (!r_outValid || bus.out_ready);
  assign w_inReady = !r_s1Valid || w_s2Load;
  assign w_inFire  = bus.in_valid && w_inReady;
  assign w_retire  = r_outValid && bus.out_ready;

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_res   = r_outRes;
  assign bus.out_flags = r_outFlags;
  assign bus.out_tag   = r_outTag;

  assign o_fpu_opd1     = r_s1Opd1;
  assign o_fpu_opd2     = r_s1Opd2;
  assign o_fpu_op       = r_s1Op;
  assign o_sticky_flags = r_sticky;
  assign o_retired_cnt  = r_retiredCnt;

  // Stage 1: the new operation wins over the s2_load clear, so a
  // simultaneous accept and forward keeps the stage occupied.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Opd1  <= '0;
      r_s1Opd2  <= '0;
      r_s1Op    <= '0;
      r_s1Tag   <= '0;
    end else if (w_inFire) begin
      r_s1Valid <= 1'b1;
      r_s1Opd1  <= bus.in_opd1;
      r_s1Opd2  <= bus.in_opd2;
      r_s1Op    <= bus.in_op;
      r_s1Tag   <= bus.in_tag;
    end else if (w_s2Load) begin
      r_s1Valid <= 1'b0;
    end
  end

  // Stage 2: capture the fpu output for the operation in stage 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outRes   <= '0;
      r_outFlags <= '0;
      r_outTag   <= '0;
    end else if (w_s2Load) begin
      r_outValid <= 1'b1;
      r_outRes   <= i_fpu_res;
      r_outFlags <= {i_fpu_ovf, i_fpu_unf, i_fpu_nan, i_fpu_zero};
      r_outTag   <= r_s1Tag;
    end else if (bus.out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // Sticky flags: a clear coinciding with a retire keeps only the flags of
  // the result retiring in that cycle, so no exception is ever lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else if (i_flag_clr && w_retire) begin
      r_sticky <= r_outFlags[3:1];
    end else if (i_flag_clr) begin
      r_sticky <= '0;
    end else if (w_retire) begin
      r_sticky <= r_sticky | r_outFlags[3:1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retiredCnt <= '0;
    end else if (w_retire) begin
      r_retiredCnt <= r_retiredCnt + 1'b1;
    end
  end

endmodule

// File: doc/fpu_pipe_ctrl.md
Name: fpu_pipe_ctrl

Overview:
- Sequential issue/retire wrapper that sits directly around the combinational fpu.
- Accepts operations over a valid/ready handshake and registers the operands into stage 1, which drives the fpu inputs.
- Captures the fpu result and flags into stage 2, which is presented downstream over a second valid/ready handshake.
- Accumulates sticky exception flags and counts retired operations.

Parameters:
- TAG_W, 4: width of the opaque tag carried alongside each operation.
- CNT_W, 16: width of the retired-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream has an operation.
- in_ready  out  1  block accepts the operation this cycle.
- in_opd1  in  32  IEEE-754 single operand 1.
- in_opd2  in  32  IEEE-754 single operand 2.
- in_op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- in_tag  in  TAG_W  tag, returned unchanged with the result.
- fpu_opd1  out  32  to fpu opd1 (stage-1 register).
- fpu_opd2  out  32  to fpu opd2 (stage-1 register).
- fpu_op  out  2  to fpu op (stage-1 register).
- fpu_res  in  32  from fpu res.
- fpu_ovf  in  1  from fpu exp_overflow.
- fpu_unf  in  1  from fpu exp_underflow.
- fpu_nan  in  1  from fpu nan.
- fpu_zero  in  1  from fpu zero.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_res  out  32  registered result.
- out_flags  out  4  {ovf, unf, nan, zero} for this result.
- out_tag  out  TAG_W  tag of this result.
- flag_clr  in  1  clear the sticky flags.
- sticky_flags  out  3  {ovf, unf, nan}; OR of all retired results since the last clear.
- retired_cnt  out  CNT_W  count of output handshakes, wrapping.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - s1_valid, out_valid = 0.
  - fpu_opd1, fpu_opd2, out_res = 0; fpu_op = 00.
  - out_flags, out_tag, sticky_flags, retired_cnt = 0.
  - in_ready evaluates to 1 during and after reset.
  - Reset mid-operation discards all in-flight operations and produces no output handshake.
- Stage enables:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_load. This is combinational from out_ready; no other combinational in-to-out path exists.
  - The input handshake fires when in_valid && in_ready.
- Stage 1:
  - On an input handshake, load the operands, op and tag; s1_valid <= 1.
  - Else if s2_load, s1_valid <= 0.
  - If no handshake and no s2_load, hold the registers unchanged.
  - The fpu inputs are driven only from these registers and stay stable while s1_valid=1 and stage 2 is stalled.
- Stage 2:
  - On s2_load, capture fpu_res, {fpu_ovf, fpu_unf, fpu_nan, fpu_zero} and the stage-1 tag; out_valid <= 1.
  - Else if out_ready, out_valid <= 0.
  - out_res, out_flags and out_tag are held stable while out_valid && !out_ready.
- Latency and throughput:
  - 2 cycles: an input handshake at edge N gives out_valid=1 after edge N+1.
  - Throughput is one operation per cycle with out_ready held at 1.
- Backpressure:
  - When out_ready=0 and both stages are full, in_ready=0.
  - No operation is dropped or duplicated. Ordering is strictly FIFO; capacity is 2 operations.
- Simultaneous events:
  - Input handshake and s2_load in the same cycle: stage 1 reloads with the new operation and stage 2 takes the old one.
- Sticky flags (retire = out_valid && out_ready):
  - flag_clr && retire: sticky_flags <= out_flags[3:1].
  - flag_clr only: sticky_flags <= 0.
  - Retire only: sticky_flags <= sticky_flags | out_flags[3:1].
- retired_cnt:
  - Increments by 1 on each retire; wraps from 2^CNT_W-1 to 0.
  - Unaffected by flag_clr.
- Op values:
  - All four op values are legal and passed through without decoding.
  - Flag meaning is whatever the fpu reports for that op.

Test Plan:
- Single add, out_ready=1: drive in_valid=1 with 0x3F800000 (1.0), 0x40000000 (2.0), op=00, tag=5 for one cycle -> 2 cycles later out_valid=1, out_res=0x40400000, out_tag=5, out_flags=0000, retired_cnt=1.
- Back-to-back stream of 8 ops (add, sub, mul, div of 3.0 and 2.0, repeated twice, tags 0..7) with out_ready=1 -> in_ready stays 1 and outputs appear one per cycle, in tag order 0..7. The first four results are 0x40A00000, 0x3F800000, 0x40C00000, 0x3FC00000.
- Backpressure: hold out_ready=0 and offer 3 ops -> only 2 are accepted and in_ready=0 while full. out_res is stable over 5 stalled cycles. After out_ready=1, all 3 retire in order with no loss.
- Sticky flags:
  - Retire a mul 0x7F000000 × 0x7F000000 (fpu_ovf=1) -> sticky_flags=100.
  - Then a normal add -> sticky_flags stays 100.
  - flag_clr pulsed alone -> sticky_flags=000.
  - flag_clr in the same cycle as an overflow retire -> sticky_flags=100.
- Reset mid-flight: with 2 ops in flight, assert rst_n=0 for 1 cycle -> out_valid=0, sticky_flags=0, retired_cnt=0, and no stale result appears afterward.
- Counter wrap (CNT_W=4): retire 17 ops -> retired_cnt reads 15 then 0 then 1.
